hs32_mem_arb: RTL and testbench
===============================

# hs32_mem_arb

Registered, parametrised N-channel internal memory arbiter; successor to the 2-channel combinational arbiter. Sits between the CPU-side requesters (fetch, load/store, DMA, debug) and the single external memory port. Latches a winning channel, holds the bus stable for that channel until the memory answers `ready`, then re-arbitrates. Fixed-priority by default; round-robin compiled in by macro.

## Interface
Parameters:
- `NCH`, 2: number of channels, ≥2.
- `AW`, 32: address width.
- `DW`, 32: data width.
- `CW`, `$clog2(NCH)`: channel index width (derived, do not override).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `addr`  out  AW  address to memory.
- `rw`  out  1  1 = write, 0 = read.
- `dout`  out  DW  write data to memory.
- `din`  in  DW  read data from memory, valid with `ready`.
- `valid`  out  1  transaction outstanding.
- `ready`  in  1  memory completed current transaction.
- `req`  in  NCH  per-channel request.
- `ch_addr`  in  NCH*AW  packed addresses; channel i at `[i*AW +: AW]`.
- `ch_rw`  in  NCH  per-channel rw.
- `ch_dtw`  in  NCH*DW  packed write data.
- `dtr`  out  DW  read data broadcast to all channels (= `din`).
- `rdy`  out  NCH  per-channel completion strobe.
- `gnt`  out  CW  index of current/last granted channel.
- `busy`  out  1  arbiter in BUSY state.

## Operation
- States: IDLE, BUSY.
- IDLE: if any `req` bit high at rising edge, select winner, latch `gnt`, register `addr`/`rw`/`dout` from winner's slice, set `valid`=1, go BUSY. Else stay IDLE, `valid`=0.
- Fixed priority (default): lowest index with `req` set wins.
- BUSY: `addr`/`rw`/`dout`/`gnt` frozen. `rdy[gnt]` = `ready` (combinational); all other `rdy` bits 0. On edge with `ready`=1: `valid`←0, go IDLE.
- `rdy` is never high in IDLE; `ready` in IDLE ignored. At most one `rdy` bit ever high.
- `dtr` = `din` always; requester captures it in its `rdy` cycle.
- Requester contract: hold `req` and payload until its `rdy`; drop `req` in the cycle after `rdy` unless issuing a new request. Withdrawing `req` while granted is illegal; arbiter completes the registered transaction anyway and still strobes `rdy`.
- Requests arriving while BUSY wait; no queueing beyond the `req` level.

## Timing
- Reset (async assert, sync-to-clk deassert by design): state IDLE, `valid`=0, `addr`=0, `rw`=0, `dout`=0, `gnt`=0, `busy`=0, `rdy`=0, RR pointer = NCH-1.
- Request latency: `req` high before edge k → `valid`/`addr` valid after edge k.
- Completion: `ready` high in cycle c → `rdy[gnt]` high in cycle c, `valid` low after edge c.
- One mandatory IDLE bubble between transactions; back-to-back throughput = 1 transaction per (memory latency + 2) cycles minimum.
- Zero-wait memory (`ready` tied high): 2-cycle period per transaction.
- `reset_n` low mid-BUSY: transaction abandoned immediately, no `rdy` issued; memory must tolerate `valid` dropping.

## Configuration
- `HS32_ARB_RR_EN` defined: round-robin. Pointer `last` updated to `gnt` on each grant; IDLE search starts at `last+1` mod NCH, wrapping. Pointer resets to NCH-1 so channel 0 wins first contention.
- Undefined: fixed priority, channel 0 highest; no pointer register.

## Test plan
- Single read, NCH=4: `req`=4'b0100, `ch_addr[2]`=0x1000, `ready` 3 cycles after `valid` with `din`=0xDEADBEEF → `addr`=0x1000, `rw`=0, `rdy`=4'b0100 one cycle, `dtr`=0xDEADBEEF, `gnt`=2.
- Contention fixed: `req`=4'b1011 held, zero-wait memory → grant order 0,0,0… (channel 0 starves others); `rdy` one-hot every 2 cycles.
- Contention RR (`HS32_ARB_RR_EN`): `req`=4'b1011 held → grant order 0,1,3,0,1,3.
- Late arrival: ch1 granted, ch0 raises `req` mid-BUSY → ch1 completes unchanged (`addr`/`dout` frozen), ch0 granted next IDLE.
- Spurious `ready` in IDLE with `req`=0 → `rdy`=0, `valid`=0, state IDLE.
- Reset mid-BUSY: assert `reset_n`=0 while `valid`=1 → all outputs 0 asynchronously, no `rdy`; after release, pending `req`=4'b0001 granted at first edge.

Source files
------------

// File: rtl/hs32_mem_arb.sv
// rtl/hs32_mem_arb.sv - registered N-channel arbiter in front of one external memory port
// Fixed priority (channel 0 highest) by default; define HS32_ARB_RR_EN for round-robin.
module hs32_mem_arb #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int CW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [AW-1:0]     addr,
  output logic              rw,
  output logic [DW-1:0]     dout,
  input  logic [DW-1:0]     din,
  output logic              valid,
  input  logic              ready,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH-1:0]    ch_rw,
  input  logic [NCH*DW-1:0] ch_dtw,
  output logic [DW-1:0]     dtr,
  output logic [NCH-1:0]    rdy,
  output logic [CW-1:0]     gnt,
  output logic              busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] win;
  logic          win_ok;
  logic          grant;

`ifdef HS32_ARB_RR_EN
  logic [CW-1:0] last;

  // Search starts one past the last winner and wraps, so every requester gets a turn.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!win_ok && req[(int'(last) + 1 + i) % NCH]) begin
        win    = CW'((int'(last) + 1 + i) % NCH);
        win_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      last <= CW'(NCH - 1);
    else if (grant)
      last <= win;
  end
`else
  // Descending scan leaves the lowest requesting index as the winner.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) begin
        win    = CW'(i);
        win_ok = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    rdy      = '0;
    case (state)
      IDLE: begin
        if (win_ok) begin
          grant    = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < NCH; i++) begin
          if (CW'(i) == gnt)
            rdy[i] = ready;
        end
        if (ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bus payload is captured only at grant and stays frozen for the whole transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      addr  <= '0;
      rw    <= 1'b0;
      dout  <= '0;
      gnt   <= '0;
    end else if (grant) begin
      valid <= 1'b1;
      gnt   <= win;
      addr  <= ch_addr[int'(win)*AW +: AW];
      rw    <= ch_rw[win];
      dout  <= ch_dtw[int'(win)*DW +: DW];
    end else if (state == BUSY && ready) begin
      valid <= 1'b0;
    end
  end

  assign busy = (state == BUSY);
  assign dtr  = din;

endmodule

// File: tb/tb_hs32_mem_arb.sv
// tb/tb_hs32_mem_arb.sv - vector table plus completion scoreboard for hs32_mem_arb (NCH=4)
module tb_hs32_mem_arb;
  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int CW  = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [AW-1:0]     addr;
  logic              rw;
  logic [DW-1:0]     dout;
  logic [DW-1:0]     din;
  logic              valid;
  logic              ready;
  logic [NCH-1:0]    req;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH-1:0]    ch_rw;
  logic [NCH*DW-1:0] ch_dtw;
  logic [DW-1:0]     dtr;
  logic [NCH-1:0]    rdy;
  logic [CW-1:0]     gnt;
  logic              busy;

  always #5 clk = ~clk;

  hs32_mem_arb #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .rw(rw), .dout(dout), .din(din),
    .valid(valid), .ready(ready), .req(req), .ch_addr(ch_addr), .ch_rw(ch_rw),
    .ch_dtw(ch_dtw), .dtr(dtr), .rdy(rdy), .gnt(gnt), .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int i);
    case (i)
      0:       return 32'h0000_0A00;
      1:       return 32'h0000_0B00;
      2:       return 32'h0000_1000;
      default: return 32'h0000_0D00;
    endcase
  endfunction

  function automatic logic [31:0] dtw_of(input int i);
    return 32'hD0D0_0000 + i;
  endfunction

  typedef struct {
    int          ch;
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [31:0] r;
  } sb_t;

  sb_t sbq[$];
  sb_t mon_e;

  task automatic push_exp(input int ch, input logic [31:0] rdata);
    sb_t e;
    e.ch = ch;
    e.a  = addr_of(ch);
    e.w  = (ch == 1);
    e.d  = dtw_of(ch);
    e.r  = rdata;
    sbq.push_back(e);
  endtask

  // Every completion strobe must match the oldest expected transaction.
  always @(negedge clk) begin
    if (rdy != '0) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_rdy: got rdy=%b required no strobe", rdy);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_rdy",  32'(rdy), 32'(1) << mon_e.ch);
        chk("sb_gnt",  32'(gnt), 32'(mon_e.ch));
        chk("sb_addr", addr, mon_e.a);
        chk("sb_rw",   32'(rw), 32'(mon_e.w));
        chk("sb_dout", dout, mon_e.d);
        chk("sb_dtr",  dtr, mon_e.r);
      end
    end
  end

  typedef struct {
    logic [3:0]  req;
    logic        rd;
    logic [31:0] din;
    logic        v;
    logic [1:0]  g;
    logic [3:0]  r;
    logic        ca;
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] rq, input logic rd, input logic [31:0] dd,
                              input logic v, input logic [1:0] g, input logic [3:0] r,
                              input logic ca, input logic [31:0] a, input logic w,
                              input logic [31:0] d);
    vec_t t;
    t.req = rq; t.rd = rd; t.din = dd; t.v = v; t.g = g; t.r = r;
    t.ca = ca; t.a = a; t.w = w; t.d = d;
    return t;
  endfunction

  vec_t vt[16];
  int   order[6];
  int   n;

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NCH; i++) begin
      ch_addr[i*AW +: AW] = addr_of(i);
      ch_dtw[i*DW +: DW]  = dtw_of(i);
      ch_rw[i]            = (i == 1);
    end
    // Spurious ready, single read of ch2, then late arrival of ch0 behind ch1.
    vt[0]  = mk(4'b0000, 1'b1, 32'h0,         1'b0, 2'd0, 4'b0000, 1'b1, 32'h0,    1'b0, 32'h0);
    vt[1]  = mk(4'b0100, 1'b0, 32'h0,         1'b0, 2'd0, 4'b0000, 1'b1, 32'h0,    1'b0, 32'h0);
    vt[2]  = mk(4'b0100, 1'b0, 32'h0,         1'b1, 2'd2, 4'b0000, 1'b1, 32'h1000, 1'b0, 32'hD0D0_0002);
    vt[3]  = mk(4'b0100, 1'b0, 32'h0,         1'b1, 2'd2, 4'b0000, 1'b1, 32'h1000, 1'b0, 32'hD0D0_0002);
    vt[4]  = mk(4'b0100, 1'b0, 32'h0,         1'b1, 2'd2, 4'b0000, 1'b1, 32'h1000, 1'b0, 32'hD0D0_0002);
    vt[5]  = mk(4'b0100, 1'b1, 32'hDEADBEEF,  1'b1, 2'd2, 4'b0100, 1'b1, 32'h1000, 1'b0, 32'hD0D0_0002);
    vt[6]  = mk(4'b0000, 1'b0, 32'h0,         1'b0, 2'd2, 4'b0000, 1'b0, 32'h0,    1'b0, 32'h0);
    vt[7]  = mk(4'b0000, 1'b1, 32'h0,         1'b0, 2'd2, 4'b0000, 1'b0, 32'h0,    1'b0, 32'h0);
    vt[8]  = mk(4'b0010, 1'b0, 32'h0,         1'b0, 2'd2, 4'b0000, 1'b0, 32'h0,    1'b0, 32'h0);
    vt[9]  = mk(4'b0010, 1'b0, 32'h0,         1'b1, 2'd1, 4'b0000, 1'b1, 32'h0B00, 1'b1, 32'hD0D0_0001);
    vt[10] = mk(4'b0011, 1'b0, 32'h0,         1'b1, 2'd1, 4'b0000, 1'b1, 32'h0B00, 1'b1, 32'hD0D0_0001);
    vt[11] = mk(4'b0011, 1'b1, 32'h1111_2222, 1'b1, 2'd1, 4'b0010, 1'b1, 32'h0B00, 1'b1, 32'hD0D0_0001);
    vt[12] = mk(4'b0001, 1'b0, 32'h0,         1'b0, 2'd1, 4'b0000, 1'b0, 32'h0,    1'b0, 32'h0);
    vt[13] = mk(4'b0001, 1'b0, 32'h0,         1'b1, 2'd0, 4'b0000, 1'b1, 32'h0A00, 1'b0, 32'hD0D0_0000);
    vt[14] = mk(4'b0001, 1'b1, 32'h3333_4444, 1'b1, 2'd0, 4'b0001, 1'b1, 32'h0A00, 1'b0, 32'hD0D0_0000);
    vt[15] = mk(4'b0000, 1'b0, 32'h0,         1'b0, 2'd0, 4'b0000, 1'b0, 32'h0,    1'b0, 32'h0);
`ifdef HS32_ARB_RR_EN
    order = '{0, 1, 3, 0, 1, 3};
`else
    order = '{0, 0, 0, 0, 0, 0};
`endif

    reset_n = 1'b0;
    req     = '0;
    ready   = 1'b0;
    din     = '0;
    #1;
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_addr",  addr,       32'h0);
    chk("rst_gnt",   32'(gnt),   32'h0);
    chk("rst_rdy",   32'(rdy),   32'h0);
    @(posedge clk); #2;
    reset_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #2;
      req   = vt[k].req;
      ready = vt[k].rd;
      din   = vt[k].din;
      if (vt[k].r != 4'b0000)
        push_exp(int'(vt[k].g), vt[k].din);
      #2;
      chk($sformatf("v%0d_valid", k), 32'(valid), 32'(vt[k].v));
      chk($sformatf("v%0d_busy", k),  32'(busy),  32'(vt[k].v));
      chk($sformatf("v%0d_gnt", k),   32'(gnt),   32'(vt[k].g));
      chk($sformatf("v%0d_rdy", k),   32'(rdy),   32'(vt[k].r));
      chk($sformatf("v%0d_dtr", k),   dtr,        vt[k].din);
      if (vt[k].ca) begin
        chk($sformatf("v%0d_addr", k), addr,     vt[k].a);
        chk($sformatf("v%0d_rw", k),   32'(rw),  32'(vt[k].w));
        chk($sformatf("v%0d_dout", k), dout,     vt[k].d);
      end
    end

    // Contention from reset with zero-wait memory: six grants in twelve cycles.
    reset_n = 1'b0;
    @(posedge clk); #2;
    req     = 4'b1011;
    ready   = 1'b1;
    din     = 32'hCAFE_F00D;
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++)
      push_exp(order[k], 32'hCAFE_F00D);
    repeat (12) @(posedge clk);
    #2;
    req   = '0;
    ready = 1'b0;
    chk("contention_drained", 32'(sbq.size()), 32'h0);

    // Reset while a transaction is outstanding.
    @(posedge clk); #2;
    req = 4'b0100;
    n   = 0;
    while (!valid && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    chk("rstbusy_reached", 32'(valid), 32'h1);
    reset_n = 1'b0;
    ready   = 1'b1;
    req     = 4'b0001;
    #1;
    chk("rstbusy_valid", 32'(valid), 32'h0);
    chk("rstbusy_busy",  32'(busy),  32'h0);
    chk("rstbusy_addr",  addr,       32'h0);
    chk("rstbusy_rw",    32'(rw),    32'h0);
    chk("rstbusy_dout",  dout,       32'h0);
    chk("rstbusy_gnt",   32'(gnt),   32'h0);
    chk("rstbusy_rdy",   32'(rdy),   32'h0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    ready   = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_valid", 32'(valid), 32'h1);
    chk("post_rst_gnt",   32'(gnt),   32'h0);
    chk("post_rst_addr",  addr,       32'h0A00);
    push_exp(0, 32'h5555_6666);
    ready = 1'b1;
    din   = 32'h5555_6666;
    @(posedge clk); #2;
    req   = '0;
    ready = 1'b0;
    chk("post_rst_done", 32'(valid), 32'h0);
    @(posedge clk); #2;
    chk("final_drained", 32'(sbq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
